// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: two-master arbiter (CPU port m0, store-buffer drain m1)
// in front of a single dcache data port.
//   - clk / resetn          : single clock, synchronous active-low reset
//   - m0_*                  : CPU request payload in, addr_ok/data_ok/rdata out
//   - m1_*                  : store-buffer word-write drain in, addr_ok/data_ok out
//   - dcache_data_*         : muxed request out, handshake/response in
// A winner that is not accepted is held (HOLD0/HOLD1) until it is accepted
// or withdraws. An order FIFO of owner IDs routes in-order responses back.
// Optional feature: define ARB_LOAD_FIRST_EN to favour m0 over m1 unless
// m1_full is set or m1 is starved; otherwise arbitration is round-robin.
module dcache_port_arbiter #(
  parameter int unsigned OST_DEPTH  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_full,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic        dcache_data_req,
  output logic        dcache_data_wr,
  output logic [1:0]  dcache_data_size,
  output logic [31:0] dcache_data_addr,
  output logic [31:0] dcache_data_wdata,
  output logic [3:0]  dcache_data_wstrb,
  input  logic [31:0] dcache_data_rdata,
  input  logic        dcache_data_addr_ok,
  input  logic        dcache_data_data_ok
);

  localparam int unsigned PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD0, S_HOLD1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OST_DEPTH-1:0] r_owner;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [SW-1:0]        r_starve;
  logic [SW-1:0]        w_starve_nxt;
  logic                 r_last;

  logic w_valid;
  logic w_sel;
  logic w_starved;
  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_head;

`ifndef ARB_LOAD_FIRST_EN
  // The store-buffer full hint only matters to the load-first policy.
  logic w_unused_full;
  assign w_unused_full = m1_full;
`endif

  assign w_starved = (r_starve == SW'(STARVE_LIM));
  assign w_full    = (r_count == CW'(OST_DEPTH));
  // Responses with nothing outstanding (e.g. after a reset) are dropped.
  assign w_pop     = resetn && dcache_data_data_ok && (r_count != '0);
  assign w_head    = r_owner[r_rptr];
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign dcache_data_req = resetn && w_valid && (!w_full || w_pop);
  assign w_accept  = dcache_data_req && dcache_data_addr_ok;

  assign m0_addr_ok = w_accept && !w_sel;
  assign m1_addr_ok = w_accept && w_sel;
  assign m0_data_ok = w_pop && !w_head;
  assign m1_data_ok = w_pop && w_head;
  assign m0_rdata   = dcache_data_rdata;

  // Payload mux; m1 is always a word write.
  assign dcache_data_wr    = w_sel ? 1'b1 : m0_wr;
  assign dcache_data_size  = w_sel ? 2'd2 : m0_size;
  assign dcache_data_addr  = w_sel ? m1_addr : m0_addr;
  assign dcache_data_wdata = w_sel ? m1_wdata : m0_wdata;
  assign dcache_data_wstrb = w_sel ? m1_wstrb : m0_wstrb;

  // Winner selection and next state.
  always_comb begin
    w_valid     = 1'b0;
    w_sel       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_valid = 1'b1;
`ifdef ARB_LOAD_FIRST_EN
          w_sel = m1_full || w_starved;
`else
          // r_last=1 means m1 won last, so m0 now has priority.
          w_sel = w_starved || !r_last;
`endif
        end else if (m0_req) begin
          w_valid = 1'b1;
        end else if (m1_req) begin
          w_valid = 1'b1;
          w_sel   = 1'b1;
        end
        if (w_valid && !w_accept) begin
          w_state_nxt = w_sel ? S_HOLD1 : S_HOLD0;
        end
      end
      S_HOLD0: begin
        w_valid = m0_req;
        if (w_accept || !m0_req) w_state_nxt = S_IDLE;
      end
      S_HOLD1: begin
        w_valid = m1_req;
        w_sel   = 1'b1;
        if (w_accept || !m1_req) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Starvation counter: m1 waiting while not itself being held.
  always_comb begin
    w_starve_nxt = r_starve;
    if (m1_addr_ok) begin
      w_starve_nxt = '0;
    end else if (m1_req && (r_state != S_HOLD1) && !w_starved) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // State, FIFO pointers, round-robin history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_last   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      if (w_accept) begin
        r_wptr <= r_wptr + PW'(1);
        r_last <= w_sel;
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_accept && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Owner ID storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_accept) r_owner[r_wptr] <= w_sel;
  end

endmodule
